// File: rtl/adc128_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | adc128_pkg: ADC128S102 frame geometry and state encoding (master+responder)  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
package adc128_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = 4;
  localparam int ADDR_FIRST_RISE = 3;
  localparam int ADDR_LAST_RISE  = 5;
  localparam int NUM_CH          = 8;
  localparam int CH_W            = $clog2(NUM_CH);

  localparam logic [1:0] WAIT_HIGH = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = WAIT_HIGH,
    ST_IDLE      = IDLE,
    ST_ACTIVE    = ACTIVE,
    ST_DONE      = DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_sync_edge: multi-stage synchronizer with registered-history edge pulses |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule
`default_nettype wire

// File: rtl/adc128_spi_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | adc128_spi_responder: ADC128S102-style SPI slave serving supplied samples    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module adc128_spi_responder
  import adc128_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic                     sclk,
  input  logic                     din,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     dout,
  output logic                     dout_oe,
  output logic [CH_W-1:0]          cur_ch,
  output logic [CH_W-1:0]          next_ch,
  output logic                     sample_stb,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] FRAME_CNT    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] ADDR2_IDX    = CNT_W'(ADDR_FIRST_RISE - 1);
  localparam logic [CNT_W-1:0] ADDR1_IDX    = CNT_W'(ADDR_FIRST_RISE);
  localparam logic [CNT_W-1:0] ADDR0_IDX    = CNT_W'(ADDR_LAST_RISE - 1);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic din_level;
  logic din_rise_unused;
  logic din_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // cs_n history resets low so a chip select already asserted at reset release
  // is never mistaken for an idle bus; a real high level must be observed first.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs_n),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk      (clk),
    .rst      (rst),
    .async_in (din),
    .level    (din_level),
    .rise     (din_rise_unused),
    .fall     (din_fall_unused)
  );

  logic [DATA_W-1:0] ch_arr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  logic [FRAME_W-1:0] start_word;
  assign start_word = {{LEAD_ZEROS{1'b0}}, ch_arr[next_ch]};

  state_t             state;
  logic [FRAME_W-2:0] shreg;
  logic [CNT_W-1:0]   fall_cnt;
  logic [CNT_W-1:0]   rise_cnt;
  logic [CH_W-1:0]    addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT_HIGH;
      shreg      <= '0;
      fall_cnt   <= '0;
      rise_cnt   <= '0;
      addr       <= '0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      cur_ch     <= '0;
      next_ch    <= '0;
      sample_stb <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_WAIT_HIGH: begin
          dout    <= 1'b0;
          dout_oe <= 1'b0;
          if (cs_level) state <= ST_IDLE;
        end

        ST_IDLE: begin
          dout    <= 1'b0;
          dout_oe <= 1'b0;
          if (cs_fall) begin
            cur_ch     <= next_ch;
            dout       <= start_word[FRAME_W-1];
            shreg      <= start_word[FRAME_W-2:0];
            dout_oe    <= 1'b1;
            sample_stb <= 1'b1;
            fall_cnt   <= '0;
            rise_cnt   <= '0;
            state      <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // A final rising edge coinciding with cs_n rise still completes the frame.
          if (sclk_rise && rise_cnt == LAST_IDX) begin
            rise_cnt   <= FRAME_CNT;
            next_ch    <= addr;
            frame_done <= 1'b1;
            dout       <= 1'b0;
            if (cs_rise) begin
              dout_oe <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state   <= ST_DONE;
            end
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            dout      <= 1'b0;
            dout_oe   <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            if (sclk_rise) begin
              rise_cnt <= rise_cnt + 1'b1;
              if (rise_cnt == ADDR2_IDX) addr[2] <= din_level;
              if (rise_cnt == ADDR1_IDX) addr[1] <= din_level;
              if (rise_cnt == ADDR0_IDX) addr[0] <= din_level;
            end
            if (sclk_fall) begin
              if (fall_cnt != FRAME_CNT) fall_cnt <= fall_cnt + 1'b1;
              dout  <= (fall_cnt < LAST_IDX) ? shreg[FRAME_W-2] : 1'b0;
              shreg <= {shreg[FRAME_W-3:0], 1'b0};
            end
          end
        end

        ST_DONE: begin
          dout <= 1'b0;
          if (cs_rise) begin
            dout_oe <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          dout    <= 1'b0;
          dout_oe <= 1'b0;
          state   <= ST_WAIT_HIGH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc128_spi_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_adc128_spi_responder: bit-banged SPI master against a frame-level model   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_adc128_spi_responder;

  localparam int DATA_W = 12;
  localparam int SYNC   = 2;
  localparam int MIN_HALF = SYNC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        sclk;
  logic        din;
  logic [8*DATA_W-1:0] ch_data;
  logic        dout;
  logic        dout_oe;
  logic [2:0]  cur_ch;
  logic [2:0]  next_ch;
  logic        sample_stb;
  logic        frame_done;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int stb_cnt  = 0;
  logic [2:0] model_next;

  adc128_spi_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .din        (din),
    .ch_data    (ch_data),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .cur_ch     (cur_ch),
    .next_ch    (next_ch),
    .sample_stb (sample_stb),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      done_cnt <= done_cnt + int'(frame_done);
      err_cnt  <= err_cnt + int'(frame_err);
      stb_cnt  <= stb_cnt + int'(sample_stb);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transaction: cs_n low, nrises sclk pulses, cs_n high.
  task automatic run_frame(input logic [2:0] addr, input int nrises, input int half,
                           input bit scramble, output logic [15:0] word);
    word = '0;
    cs_n = 1'b0;
    clks(half);
    check("oe_at_start", {31'd0, dout_oe}, 32'd1);
    word[15] = dout;
    for (int k = 1; k <= nrises; k++) begin
      sclk = 1'b0;
      din  = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom);
      if (scramble && k == 2) ch_data = '0;
      clks(half);
      if (k <= 15) word[15-k] = dout;
      else check("dout_after_fall16", {31'd0, dout}, 32'd0);
      sclk = 1'b1;
      clks(half);
    end
    cs_n = 1'b1;
    clks(half + 4);
  endtask

  task automatic frame_and_check(input logic [2:0] addr, input int nrises, input int half,
                                 input bit scramble);
    logic [15:0] exp_word;
    logic [15:0] word;
    logic [2:0]  served;
    int d0, e0, s0, sh;
    served   = model_next;
    exp_word = {4'h0, ch_data[int'(served)*DATA_W +: DATA_W]};
    d0 = done_cnt; e0 = err_cnt; s0 = stb_cnt;
    run_frame(addr, nrises, half, scramble, word);
    check("cur_ch", {29'd0, cur_ch}, {29'd0, served});
    check("sample_stb_count", stb_cnt - s0, 32'd1);
    if (nrises >= 16) begin
      model_next = addr;
      check("word", {16'd0, word}, {16'd0, exp_word});
      check("frame_done_count", done_cnt - d0, 32'd1);
      check("frame_err_count", err_cnt - e0, 32'd0);
    end else begin
      sh = 15 - nrises;
      check("partial_word", {16'd0, word} >> sh, {16'd0, exp_word} >> sh);
      check("frame_done_count", done_cnt - d0, 32'd0);
      check("frame_err_count", err_cnt - e0, 32'd1);
    end
    check("next_ch", {29'd0, next_ch}, {29'd0, model_next});
    check("oe_after_cs_high", {31'd0, dout_oe}, 32'd0);
    check("dout_after_cs_high", {31'd0, dout}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int s0;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; din = 1'b0;
    for (int c = 0; c < 8; c++) ch_data[c*DATA_W +: DATA_W] = 12'($urandom);
    model_next = 3'd0;
    clks(5);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_oe", {31'd0, dout_oe}, 32'd0);
    check("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
    check("rst_next_ch", {29'd0, next_ch}, 32'd0);
    check("rst_pulses", {29'd0, sample_stb, frame_done, frame_err}, 32'd0);
    rst = 1'b0;
    clks(6);

    // Frame 1: ch0 served first after reset, address 5 committed.
    ch_data[0 +: DATA_W] = 12'hABC;
    frame_and_check(3'b101, 16, 6, 1'b0);

    // Frame 2: pipelined address now serves ch5.
    ch_data[5*DATA_W +: DATA_W] = 12'h123;
    frame_and_check(3'b010, 16, 6, 1'b0);

    // Early cs_n rise after 10 rising edges.
    frame_and_check(3'($urandom), 10, 5, 1'b0);

    // Reset mid-frame while cs_n stays low: no response until cs_n cycles.
    cs_n = 1'b0;
    clks(6);
    sclk = 1'b0; clks(5); sclk = 1'b1; clks(5);
    rst = 1'b1;
    clks(1);
    check("midrst_oe", {31'd0, dout_oe}, 32'd0);
    check("midrst_next_ch", {29'd0, next_ch}, 32'd0);
    clks(2);
    rst = 1'b0;
    model_next = 3'd0;
    s0 = stb_cnt;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b0; din = 1'($urandom); clks(5);
      check("held_low_oe_dout", {30'd0, dout_oe, dout}, 32'd0);
      sclk = 1'b1; clks(5);
    end
    check("held_low_no_stb", stb_cnt - s0, 32'd0);
    cs_n = 1'b1;
    clks(8);
    frame_and_check(3'($urandom), 16, 6, 1'b0);

    // 18 pulses in one frame: extra edges ignored.
    frame_and_check(3'($urandom), 18, 5, 1'b0);

    // Sample frozen at frame start; minimum sclk half-period.
    ch_data[int'(model_next)*DATA_W +: DATA_W] = 12'hFFF;
    frame_and_check(3'($urandom), 16, MIN_HALF, 1'b1);
    check("frozen_sample_reset_in", {20'd0, ch_data[11:0]}, 32'd0);

    // Randomized frames.
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < 8; c++) ch_data[c*DATA_W +: DATA_W] = 12'($urandom);
      frame_and_check(3'($urandom), 16, int'($urandom_range(MIN_HALF, 8)), 1'b0);
    end

    w = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
